// File: rtl/mem_bus_master.sv
// mem_bus_master: initiator for the 8-bit shared-bus memory interface.
// Takes one read or write request at a time over a valid/ready handshake.
// It sequences the SETUP / STROBE / RWAIT / RESP cycles on the bus.
// It then returns a single-cycle response pulse.
// Optional feature macro: MEM_WRITE_VERIFY_EN. When it is defined, every
// write is followed by a read-back of the same address. A mismatch between
// the read-back byte and the written byte is flagged on rsp_err.
module mem_bus_master #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              mem_cs
);

  // READ_LATENCY is limited to 1..15, so a 4-bit down-counter is enough.
  localparam logic [3:0] RD_LAT = 4'(READ_LATENCY);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    RWAIT  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                write_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                accept;
  logic                sample;
  logic                drive_en;

  assign accept = (state_q == IDLE) && req_valid;
  // The bus byte is captured on the edge that closes the final wait cycle.
  assign sample = (state_q == RWAIT) && (cnt_q == 4'd1);

  // State register: the asynchronous reset drops any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the wait counter for read (or read-back) latency.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) state_d = SETUP;
      end
      SETUP: begin
        if (write_q) begin
          state_d = STROBE;
        end else begin
          state_d = RWAIT;
          cnt_d   = RD_LAT;
        end
      end
      STROBE: begin
`ifdef MEM_WRITE_VERIFY_EN
        state_d = RWAIT;
        cnt_d   = RD_LAT;
`else
        state_d = RESP;
`endif
      end
      RWAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request latch and wait counter: pure datapath, so they have no reset.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
    if (accept) begin
      wdata_q <= req_wdata;
      write_q <= req_write;
    end
  end

  // The address is reset to zero and then holds the last access address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else if (accept) begin
      addr_q <= req_addr;
    end
  end

  // Read data (and write-verify error) captured at the end of RWAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (sample) begin
      rdata_q <= mem_data;
`ifdef MEM_WRITE_VERIFY_EN
      err_q   <= write_q && (mem_data != wdata_q);
`else
      err_q   <= 1'b0;
`endif
    end
  end

  // The master drives the bus only during a write's SETUP and STROBE
  // cycles. Whenever we=0 after that, the bus is left to the memory.
  assign drive_en  = ((state_q == SETUP) && write_q) || (state_q == STROBE);
  assign mem_data  = drive_en ? wdata_q : {DATA_W{1'bz}};
  assign mem_addr  = addr_q;
  assign mem_cs    = (state_q == SETUP) || (state_q == STROBE) || (state_q == RWAIT);
  assign mem_we    = (state_q == STROBE);
  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
`ifdef MEM_WRITE_VERIFY_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Testbench for mem_bus_master.
// Two instances share the bench: one with READ_LATENCY=1, one with READ_LATENCY=3.
// Each instance has its own behavioural memory on a pulled-up bus.
// A scoreboard queue holds the expected responses.
module tb_mem_bus_master;

`ifdef MEM_WRITE_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  typedef struct {
    logic [7:0] rd;
    logic       err;
    int         hs;
    int         lat;
    logic       wr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        mem_init;
  logic        stuck0;
  logic        req_valid;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;

  logic        v0, v1, ready0, ready1, rspv0, rspv1, err0, err1;
  logic        we0, we1, cs0, cs1;
  logic [7:0]  rd0, rd1;
  logic [15:0] ad0, ad1;
  wire  [7:0]  md0, md1;

  logic        rdy_m, rspv_m, err_m, we_m, cs_m;
  logic [7:0]  rd_m, md_m;
  logic [15:0] ad_m;

  logic [7:0]  mem0 [256];
  logic [7:0]  mem1 [256];
  logic [7:0]  ref_m [2][256];
  logic [7:0]  last_rd [2];
  logic        pcs0, pcs1;

  exp_t        q[$];
  int          hs_log[$];
  exp_t        e;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          viol = 0;

  always #5 clk = ~clk;

  assign v0 = req_valid && !sel;
  assign v1 = req_valid && sel;

  mem_bus_master #(.ADDR_W(16), .DATA_W(8), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(v0), .req_ready(ready0), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rspv0), .rsp_rdata(rd0), .rsp_err(err0),
    .mem_addr(ad0), .mem_data(md0), .mem_we(we0), .mem_cs(cs0)
  );

  mem_bus_master #(.ADDR_W(16), .DATA_W(8), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(v1), .req_ready(ready1), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rspv1), .rsp_rdata(rd1), .rsp_err(err1),
    .mem_addr(ad1), .mem_data(md1), .mem_we(we1), .mem_cs(cs1)
  );

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (md0[i]);
    pullup (md1[i]);
  end

  // Memory models: they drive read data from the second cs cycle with we=0 onward.
  // Write data is captured on the edge that ends the we=1 cycle.
  // Memory 0 can be given a bit 0 that is stuck at 0.
  assign md0 = (cs0 && !we0 && pcs0) ? mem0[ad0[7:0]] : 8'bz;
  assign md1 = (cs1 && !we1 && pcs1) ? mem1[ad1[7:0]] : 8'bz;

  always @(posedge clk) begin
    pcs0 <= cs0;
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem0[i] <= 8'(i) ^ 8'hA5;
    end else if (cs0 && we0) begin
      mem0[ad0[7:0]] <= md0 & (stuck0 ? 8'hFE : 8'hFF);
    end
  end

  always @(posedge clk) begin
    pcs1 <= cs1;
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem1[i] <= 8'(i) ^ 8'hA5;
    end else if (cs1 && we1) begin
      mem1[ad1[7:0]] <= md1;
    end
  end

  assign rdy_m  = sel ? ready1 : ready0;
  assign rspv_m = sel ? rspv1  : rspv0;
  assign err_m  = sel ? err1   : err0;
  assign we_m   = sel ? we1    : we0;
  assign cs_m   = sel ? cs1    : cs0;
  assign rd_m   = sel ? rd1    : rd0;
  assign md_m   = sel ? md1    : md0;
  assign ad_m   = sel ? ad1    : ad0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: push an expectation on each handshake, then pop and compare on each response.
  always @(negedge clk) begin
    logic [7:0] a, stored;
    int         l;
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        ref_m[0][i] = 8'(i) ^ 8'hA5;
        ref_m[1][i] = 8'(i) ^ 8'hA5;
      end
    end
    if (rst) begin
      q.delete();
      last_rd[0] = 8'h00;
      last_rd[1] = 8'h00;
    end else begin
      l = sel ? 3 : 1;
      if (req_valid && rdy_m) begin
        e.hs = cyc + 1;
        e.wr = req_write;
        a    = req_addr[7:0];
        if (req_write) begin
          stored = req_wdata & ((stuck0 && !sel) ? 8'hFE : 8'hFF);
          ref_m[sel][a] = stored;
          if (VFY) begin
            e.rd = stored;
            e.err = (stored != req_wdata);
            e.lat = 3 + l;
            last_rd[sel] = stored;
          end else begin
            e.rd = last_rd[sel];
            e.err = 1'b0;
            e.lat = 3;
          end
        end else begin
          e.rd  = ref_m[sel][a];
          e.err = 1'b0;
          e.lat = 2 + l;
          last_rd[sel] = e.rd;
        end
        q.push_back(e);
        hs_log.push_back(e.hs);
      end
      if (rspv_m) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rsp_rdata", 32'(rd_m), 32'(e.rd));
          chk("rsp_err", 32'(err_m), 32'(e.err));
          chk("rsp_latency", 32'(cyc - e.hs + 1), 32'(e.lat));
        end
      end
      // Bus rules: the bus is released whenever cs is low, and we stays low during reads.
      if (!cs_m && md_m !== 8'hFF) viol++;
      if (q.size() != 0 && !q[0].wr && we_m) viol++;
    end
  end

  task automatic set_req(input logic wr, input logic [15:0] a, input logic [7:0] d);
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic do_req(input logic wr, input logic [15:0] a, input logic [7:0] d);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1;
    set_req(wr, a, d);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy_m && n < 50);
    chk("req_accept", 32'(rdy_m), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, csn, n0;
    int wlat1, rlat1;
    logic        tw [4];
    logic [7:0]  td [4];
    tw = '{1'b1, 1'b0, 1'b1, 1'b0};
    td = '{8'h3C, 8'h00, 8'hC3, 8'h00};
    rst = 1'b1; mem_init = 1'b1; sel = 1'b0; stuck0 = 1'b0;
    req_valid = 1'b0; set_req(1'b0, 16'h0000, 8'h00);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cs", 32'(cs0), 32'd0);
    chk("rst_we", 32'(we0), 32'd0);
    chk("rst_ready", 32'(ready0), 32'd0);
    chk("rst_rspv", 32'(rspv0), 32'd0);
    chk("rst_rdata", 32'(rd0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_addr", 32'(ad0), 32'd0);
    chk("rst_bus", 32'(md0), 32'hFF);
    @(posedge clk); #1;
    rst = 1'b0; mem_init = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(ready0), 32'd1);

    // Write 0xFF to 0x0001, checked cycle by cycle (READ_LATENCY=1)
    @(posedge clk); #1;
    req_valid = 1'b1; set_req(1'b1, 16'h0001, 8'hFF);
    @(negedge clk);
    chk("t1_ready", 32'(rdy_m), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("t1_setup_cs", 32'(cs_m), 32'd1);
    chk("t1_setup_we", 32'(we_m), 32'd0);
    chk("t1_setup_addr", 32'(ad_m), 32'h0001);
    chk("t1_setup_bus", 32'(md_m), 32'hFF);
    chk("t1_setup_ready", 32'(rdy_m), 32'd0);
    @(negedge clk);
    chk("t1_strobe_cs", 32'(cs_m), 32'd1);
    chk("t1_strobe_we", 32'(we_m), 32'd1);
    chk("t1_strobe_bus", 32'(md_m), 32'hFF);
    @(negedge clk);
    chk("t1_post_we", 32'(we_m), 32'd0);
    chk("t1_post_cs", 32'(cs_m), 32'(VFY));
    wait_done();
    chk("t1_addr_hold", 32'(ad_m), 32'h0001);
    chk("t1_idle_ready", 32'(rdy_m), 32'd1);

    // Write 0x00 to 0x0020, then read 0x0001
    do_req(1'b1, 16'h0020, 8'h00);
    wait_done();
    do_req(1'b0, 16'h0001, 8'h00);
    wait_done();

    // READ_LATENCY=3: write 0x5A to 0x0020, then read it back and count cs cycles
    sel = 1'b1;
    do_req(1'b1, 16'h0020, 8'h5A);
    wait_done();
    do_req(1'b0, 16'h0020, 8'h00);
    n = 0; csn = 0;
    do begin
      @(negedge clk);
      n++;
      if (cs_m) csn++;
    end while (!rspv_m && n < 20);
    chk("t3_cs_cycles", 32'(csn), 32'd4);
    wait_done();

    // Back-to-back requests with req_valid held high (READ_LATENCY=1)
    sel = 1'b0;
    wlat1 = VFY ? 4 : 3;
    rlat1 = 3;
    n0 = hs_log.size();
    @(posedge clk); #1;
    req_valid = 1'b1;
    set_req(tw[0], 16'h0000, td[0]);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rdy_m && n < 50);
      chk("t4_accept", 32'(rdy_m), 32'd1);
      @(posedge clk); #1;
      if (k < 3) set_req(tw[k+1], 16'(k + 1), td[k+1]);
      else req_valid = 1'b0;
    end
    wait_done();
    for (int k = 1; k < 4; k++) begin
      chk("t4_gap", 32'(hs_log[n0+k] - hs_log[n0+k-1]), 32'((tw[k-1] ? wlat1 : rlat1) + 1));
    end

    // Asynchronous reset in the middle of RWAIT (READ_LATENCY=3)
    sel = 1'b1;
    do_req(1'b0, 16'h0021, 8'h00);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_cs", 32'(cs_m), 32'd0);
    chk("t5_we", 32'(we_m), 32'd0);
    chk("t5_bus", 32'(md_m), 32'hFF);
    chk("t5_ready", 32'(rdy_m), 32'd0);
    chk("t5_rspv", 32'(rspv_m), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_ready_after", 32'(rdy_m), 32'd1);
    repeat (6) @(negedge clk);
    do_req(1'b0, 16'h0020, 8'h00);
    wait_done();

    // Memory 0 with bit 0 stuck at 0: write 0x01, then write 0x02
    sel = 1'b0;
    stuck0 = 1'b1;
    do_req(1'b1, 16'h0030, 8'h01);
    wait_done();
    do_req(1'b1, 16'h0031, 8'h02);
    wait_done();
    stuck0 = 1'b0;
    do_req(1'b0, 16'h0030, 8'h00);
    wait_done();

    chk("bus_rules", 32'(viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
